// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared types and constants for the SRAM-like responder.
// Holds size codes, the queued-request entry type and the stall LFSR constants.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Full word address is kept; the top slices
  // it down to the memory index width.
  localparam int IDX_W = 30;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic             wr;
    logic [IDX_W-1:0] index;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: in-order queue of accepted requests with per-entry countdown.
// Ports: clk, rst (async, low), push/din, pop/head, full, empty, head_eligible.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic   head_eligible
);

  localparam int PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(DEPTH - 1);
  localparam logic [PW:0] CAP =
    (PW + 1)'(DEPTH);

  entry_t           q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] push_mask;
  logic [DEPTH-1:0] pop_mask;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push_mask = '0;
    pop_mask  = '0;
    push_mask[wr_ptr] = push;
    pop_mask[rd_ptr]  = pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      vld <= (vld | push_mask) & ~pop_mask;
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: vld gates every use.
  // A fresh push loads cnt; older entries count
  // down independently until they reach zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_mask[i]) begin
        q[i] <= din;
      end else if (vld[i] && q[i].cnt != '0) begin
        q[i].cnt <= q[i].cnt - 1'b1;
      end
    end
  end

  assign head  = q[rd_ptr];
  assign full  = (count == CAP);
  assign empty = (count == '0);

  assign head_eligible =
    vld[rd_ptr] && (head.cnt == '0);

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like slave port backed by a word memory with fixed latency.
// Ports: clk, rst (async, low), req/wr/size/addr/wdata/wstrb in; addr_ok, data_ok, rdata out. Macro: SRAM_LIKE_RAND_STALL_EN.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int DEPTH     = 2,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int IW = $clog2(MEM_WORDS);

  logic          full;
  logic          empty;
  logic          head_eligible;
  logic          push;
  logic          pop;
  logic          stall;
  entry_t        din;
  entry_t        head;
  logic [IW-1:0] hidx;
  logic [31:0]   mem [MEM_WORDS];

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // full is registered, so a pop this cycle
  // never reopens addr_ok early.
  assign addr_ok = rst && !full && !stall;
  assign push    = req && addr_ok;
  assign pop     = !empty && head_eligible;

  always_comb begin
    din       = '0;
    din.wr    = wr;
    din.index = addr[31:2];
    din.wdata = wdata;
    din.wstrb = wstrb;
    din.cnt   = CNT_W'(LATENCY - 1);
  end

  sram_like_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .din           (din),
    .pop           (pop),
    .head          (head),
    .full          (full),
    .empty         (empty),
    .head_eligible (head_eligible)
  );

  // Index wraps modulo MEM_WORDS by slicing.
  assign hidx = head.index[IW-1:0];

  // Memory is touched only at response time,
  // so accesses follow queue order exactly.
  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (head.wstrb[i]) begin
          mem[hidx][8*i +: 8] <=
            head.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= pop;
      if (pop && !head.wr) begin
        rdata <= mem[hidx];
      end
    end
  end

  // size is informational; wstrb decides lanes.
  logic unused_ok;
  assign unused_ok =
    ^{size, addr[1:0], head.index};

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: three responder instances (LATENCY 2/4/1) vs a transaction model.
// Model predicts each response at accept edge + LATENCY and applies memory effects in order.
module tb_sram_like_responder;

  localparam int N = 3;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req     [N];
  logic        wr      [N];
  logic [1:0]  size    [N];
  logic [31:0] addr    [N];
  logic [31:0] wdata   [N];
  logic [3:0]  wstrb   [N];
  logic        addr_ok [N];
  logic        data_ok [N];
  logic [31:0] rdata   [N];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_acc;

  sram_like_responder #(
    .MEM_WORDS(1024), .DEPTH(2), .LATENCY(2)
  ) u_a (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]),
    .size(size[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .addr_ok(addr_ok[0]),
    .data_ok(data_ok[0]), .rdata(rdata[0])
  );

  sram_like_responder #(
    .MEM_WORDS(1024), .DEPTH(2), .LATENCY(4)
  ) u_b (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]),
    .size(size[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .addr_ok(addr_ok[1]),
    .data_ok(data_ok[1]), .rdata(rdata[1])
  );

  sram_like_responder #(
    .MEM_WORDS(1024), .DEPTH(2), .LATENCY(1)
  ) u_c (
    .clk(clk), .rst(rst), .req(req[2]), .wr(wr[2]),
    .size(size[2]), .addr(addr[2]), .wdata(wdata[2]),
    .wstrb(wstrb[2]), .addr_ok(addr_ok[2]),
    .data_ok(data_ok[2]), .rdata(rdata[2])
  );

  function automatic int lat(int i);
    return (i == 0) ? 2 : (i == 1) ? 4 : 1;
  endfunction

  task automatic chk(string name,
                     logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               name, got, exp);
    end
  endtask

  // model state
  logic [31:0] mm       [N][1024];
  int          qdue     [N][16];
  logic        qwr      [N][16];
  logic [9:0]  qidx     [N][16];
  logic [31:0] qdat     [N][16];
  logic [3:0]  qstb     [N][16];
  int          qh       [N];
  int          qt       [N];
  logic [31:0] ex_rdata [N];
  logic [15:0] mlfsr = 16'hACE1;

  // observed responses
  int          lg_cyc [N][256];
  logic [31:0] lg_dat [N][256];
  int          lg_n   [N];

  initial begin
    logic edok;
    logic eaok;
    logic stl;
    int   k;
    for (int i = 0; i < N; i++) begin
      qh[i] = 0; qt[i] = 0; lg_n[i] = 0;
      ex_rdata[i] = '0;
    end
    forever begin
      @(negedge clk);
      stl = 1'b0;
`ifdef SRAM_LIKE_RAND_STALL_EN
      if (!rst) mlfsr = 16'hACE1;
      else mlfsr = {mlfsr[14:0],
                    mlfsr[15] ^ mlfsr[13] ^
                    mlfsr[12] ^ mlfsr[10]};
      stl = mlfsr[0];
`endif
      for (int i = 0; i < N; i++) begin
        edok = 1'b0;
        if (!rst) begin
          qh[i] = 0; qt[i] = 0;
          ex_rdata[i] = '0;
        end else if (qt[i] != qh[i] &&
                     qdue[i][qh[i] & 15] == cyc) begin
          k = qh[i] & 15;
          edok = 1'b1;
          if (qwr[i][k]) begin
            for (int b = 0; b < 4; b++)
              if (qstb[i][k][b])
                mm[i][qidx[i][k]][8*b +: 8] =
                  qdat[i][k][8*b +: 8];
          end else begin
            ex_rdata[i] = mm[i][qidx[i][k]];
          end
          qh[i]++;
        end
        eaok = rst && ((qt[i] - qh[i]) < D) && !stl;
        chk($sformatf("data_ok i%0d c%0d", i, cyc),
            32'(data_ok[i]), 32'(edok));
        chk($sformatf("addr_ok i%0d c%0d", i, cyc),
            32'(addr_ok[i]), 32'(eaok));
        chk($sformatf("rdata i%0d c%0d", i, cyc),
            rdata[i], ex_rdata[i]);
        if (data_ok[i] && lg_n[i] < 256) begin
          lg_cyc[i][lg_n[i]] = cyc;
          lg_dat[i][lg_n[i]] = rdata[i];
          lg_n[i]++;
        end
        if (rst && req[i] && eaok) begin
          k = qt[i] & 15;
          qdue[i][k] = cyc + 1 + lat(i);
          qwr[i][k]  = wr[i];
          qidx[i][k] = addr[i][11:2];
          qdat[i][k] = wdata[i];
          qstb[i][k] = wstrb[i];
          qt[i]++;
        end
      end
    end
  end

  task automatic put(int i, bit w,
                     logic [31:0] a,
                     logic [31:0] d,
                     logic [3:0] s);
    bit got = 1'b0;
    req[i] = 1'b1; wr[i] = w;
    addr[i] = a; wdata[i] = d; wstrb[i] = s;
    size[i] = (s == 4'hF) ? 2'd2 : 2'd0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (addr_ok[i]) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout i%0d", i);
    end
    @(posedge clk); #1;
    last_acc = cyc;
  endtask

  task automatic stop(int i);
    req[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int a0, a1, a2, n0, nr;

  initial begin
    for (int i = 0; i < N; i++) begin
      req[i] = 0; wr[i] = 0; size[i] = 0;
      addr[i] = 0; wdata[i] = 0; wstrb[i] = 0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_data_ok", 32'(data_ok[0]), 0);
    chk("reset_addr_ok", 32'(addr_ok[0]), 0);
    chk("reset_rdata", rdata[0], 0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(1);

    // write then read, LATENCY 2
    n0 = lg_n[0];
    put(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    a0 = last_acc;
    put(0, 0, 32'h10, 32'h0, 4'h0);
    a1 = last_acc;
    stop(0);
    wait_cyc(5);
    chk("t1_count", lg_n[0] - n0, 2);
    chk("t1_rdata", lg_dat[0][n0 + 1], 32'hDEAD_BEEF);
`ifndef SRAM_LIKE_RAND_STALL_EN
    chk("t1_acc_gap", a1 - a0, 1);
    chk("t1_dok0", lg_cyc[0][n0] - a0, 2);
    chk("t1_dok1", lg_cyc[0][n0 + 1] - a0, 3);
`endif

    // byte strobe
    put(0, 1, 32'h10, 32'h1122_3344, 4'hF);
    put(0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101);
    put(0, 0, 32'h10, 32'h0, 4'h0);
    stop(0);
    wait_cyc(6);
    chk("strobe_rdata", rdata[0], 32'h11BB_33DD);

    // index wrap and empty strobe
    n0 = lg_n[0];
    put(0, 1, 32'h0000_1020, 32'h55AA_55AA, 4'hF);
    put(0, 1, 32'h20, 32'h0, 4'h0);
    put(0, 0, 32'h20, 32'h0, 4'h0);
    stop(0);
    wait_cyc(6);
    chk("wrap_rdata", rdata[0], 32'h55AA_55AA);
    chk("wstrb0_count", lg_n[0] - n0, 3);

    // full queue, LATENCY 4
    put(1, 1, 32'h0, 32'h0A0A_0A0A, 4'hF);
    stop(1);
    wait_cyc(6);
    n0 = lg_n[1];
    put(1, 0, 32'h0, 32'h0, 4'h0);
    a0 = last_acc;
    put(1, 0, 32'h0, 32'h0, 4'h0);
    a1 = last_acc;
    put(1, 0, 32'h0, 32'h0, 4'h0);
    a2 = last_acc;
    stop(1);
    wait_cyc(12);
    chk("full_count", lg_n[1] - n0, 3);
    chk("full_rdata", lg_dat[1][n0 + 2], 32'h0A0A_0A0A);
`ifndef SRAM_LIKE_RAND_STALL_EN
    chk("full_acc1", a1 - a0, 1);
    chk("full_acc2", a2 - a0, 5);
    chk("full_dok0", lg_cyc[1][n0] - a0, 4);
    chk("full_dok1", lg_cyc[1][n0 + 1] - a0, 5);
    chk("full_dok2", lg_cyc[1][n0 + 2] - a0, 9);
`endif

    // LATENCY 1 streaming
    for (int k = 0; k < 8; k++)
      put(2, 1, 32'(k * 4), 32'hC0DE_0000 + 32'(k), 4'hF);
    stop(2);
    wait_cyc(4);
    n0 = lg_n[2];
    for (int k = 0; k < 8; k++) begin
      put(2, 0, 32'(k * 4), 32'h0, 4'h0);
      if (k == 0) a0 = last_acc;
    end
    stop(2);
    wait_cyc(4);
    chk("stream_count", lg_n[2] - n0, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stream_dat%0d", k),
          lg_dat[2][n0 + k], 32'hC0DE_0000 + 32'(k));
`ifndef SRAM_LIKE_RAND_STALL_EN
      chk($sformatf("stream_cyc%0d", k),
          lg_cyc[2][n0 + k] - a0, k + 1);
`endif
    end

    // reset mid-operation
    put(0, 0, 32'h10, 32'h0, 4'h0);
    put(0, 0, 32'h20, 32'h0, 4'h0);
    stop(0);
    @(posedge clk); #3;
`ifndef SRAM_LIKE_RAND_STALL_EN
    chk("rst_pre_dok", 32'(data_ok[0]), 1);
`endif
    rst = 1'b0;
    #1;
    chk("rst_mid_dok", 32'(data_ok[0]), 0);
    chk("rst_mid_aok", 32'(addr_ok[0]), 0);
    chk("rst_mid_rdata", rdata[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    nr = lg_n[0];
    wait_cyc(6);
    chk("rst_no_stale", lg_n[0] - nr, 0);
    put(0, 0, 32'h20, 32'h0, 4'h0);
    stop(0);
    wait_cyc(5);
    chk("rst_after_rdata", rdata[0], 32'h55AA_55AA);

    // random traffic on words 0..7
    n0 = lg_n[0];
    for (int k = 0; k < 8; k++)
      put(0, 1, 32'(k * 4), 32'h3000_0000 + 32'(k), 4'hF);
    for (int k = 0; k < 100; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        stop(0);
        wait_cyc(gap);
      end
      put(0, 1'($urandom_range(0, 1)),
          ($urandom & 32'hFFFF_F000) |
          32'($urandom_range(0, 7) * 4) |
          32'($urandom_range(0, 3)),
          $urandom, 4'($urandom_range(0, 15)));
    end
    stop(0);
    wait_cyc(10);
    chk("rand_count", lg_n[0] - n0, 108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave/responder end of the SRAM-like instruction/data port the MIPS core drives (req/wr/addr_ok/data_ok).
- Backs one port with an internal word memory and configurable response latency, giving the core and its cache a cycle-accurate memory model for bring-up and unit verification.
- Supports up to DEPTH outstanding requests; responses return strictly in order.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; word index = addr[log2(MEM_WORDS)+1:2], wraps modulo MEM_WORDS.
- DEPTH, 2, outstanding-request queue depth (power of two, >=1).
- LATENCY, 2, cycles from accept edge to data_ok sample edge (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- req  input  1  request valid from master.
- wr  input  1  1 = write, 0 = read.
- size  input  2  0 = byte, 1 = half, 2 = word; recorded only, wstrb is authoritative.
- addr  input  32  byte address; addr[1:0] ignored for indexing.
- wdata  input  32  write data.
- wstrb  input  4  byte-lane write enables; lane i = wdata[8i+7:8i].
- addr_ok  output  1  request accepted this cycle when req && addr_ok.
- data_ok  output  1  one-cycle pulse per accepted request, in order.
- rdata  output  32  read data, valid only while data_ok is high for a read; holds last value otherwise.

Behaviour:
- Reset:
  - Queue emptied; data_ok = 0, rdata = 0.
  - addr_ok = 0 while rst = 0.
  - Memory contents are not reset; simulation preload only.
- Accept:
  - At an edge with req && addr_ok, push entry {wr, index, wdata, wstrb, cnt = LATENCY-1}.
  - addr_ok is combinational: rst && !full. There is no full-queue bypass: when full, addr_ok = 0 even if a pop occurs that cycle.
- Countdown:
  - Every edge, each valid entry with cnt > 0 decrements its cnt.
  - The head entry becomes eligible when its cnt = 0.
- Response (registered):
  - At the edge after the head becomes eligible, data_ok <= 1 and the head is popped.
  - Read: rdata <= mem[index].
  - Write: mem[index] bytes updated per wstrb; rdata unchanged.
  - Net effect: a request accepted at edge N is seen as data_ok = 1 at edge N+LATENCY. With LATENCY = 1, data_ok is high in the cycle immediately after acceptance.
- Back-to-back: one response per cycle maximum; consecutive eligible entries yield consecutive data_ok pulses.
- Ordering:
  - Memory is accessed only at response time, in queue order.
  - A read queued behind a write to the same word returns the written data.
- Simultaneous push and pop in the same edge is legal; the count is unchanged.
- The master has no ready signal. data_ok is never held; the master must accept it.
- Reset mid-operation: all outstanding entries are dropped, no data_ok is issued for them, and memory writes not yet responded are lost.
- wstrb = 0 on a write: data_ok is still issued; memory is unchanged.

Optional Feature:
- Macro: SRAM_LIKE_RAND_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 16'hACE1 on reset) advances every cycle.
  - addr_ok = rst && !full && !lfsr[0].
  - Latency and data path are unchanged. This stresses the master's addr_ok handling.
- Undefined: no LFSR exists; addr_ok = rst && !full.

Decomposition:
- Package sram_like_pkg holds:
  - Size code constants: SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - The entry typedef {wr, index, wdata, wstrb, cnt}.
  - LFSR seed and tap constants.
- Sub-module sram_like_resp_fifo:
  - DEPTH-entry circular queue with per-entry cnt decrement.
  - Outputs full, empty, and head_eligible.
- Top level owns the memory array, byte-lane write, rdata register and addr_ok logic.

Test Plan:
- Single word write then read, LATENCY = 2, macro off:
  - Stimulus: write addr = 32'h0000_0010, wdata = 32'hDEAD_BEEF, wstrb = 4'hF, accepted at edge 0; then read same addr accepted at edge 1.
  - Required: data_ok at edges 2 and 3; rdata = 32'hDEAD_BEEF at edge 3.
- Byte strobe:
  - Stimulus: mem[4] = 32'h1122_3344; write addr = 32'h10, wdata = 32'hAABB_CCDD, wstrb = 4'b0101; then read addr = 32'h10.
  - Required: rdata = 32'h11BB_33DD.
- Full queue, DEPTH = 2, LATENCY = 4:
  - Stimulus: req held high.
  - Required: accepts at edges 0 and 1; addr_ok = 0 from edge 1 until the edge-4 pop; next accept at edge 5; data_ok at edges 4, 5 and 9.
- LATENCY = 1 streaming:
  - Stimulus: 8 consecutive reads of addr 0x0, 0x4, …, 0x1C.
  - Required: data_ok high 8 consecutive cycles; rdata matches the preload in order.
- Reset mid-operation:
  - Stimulus: 2 reads outstanding; rst = 0 asynchronously mid-cycle.
  - Required: data_ok = 0 and addr_ok = 0 immediately; no data_ok after release; the next request responds normally.
- SRAM_LIKE_RAND_STALL_EN defined:
  - Stimulus: 100 random requests.
  - Required: addr_ok is low exactly when lfsr[0] = 1 or the queue is full; all 100 data_ok pulses occur in order with data correct against a scoreboard.
